// File: rtl/bullet_pool_if.sv
// Fire request/response handshake between the tank control logic and bullet_pool.
// Control logic is the master; the pool answers each fire_req with fire_ack or fire_drop.
interface bullet_pool_if #(
  parameter int unsigned POS_W = 5
);
  logic             fire_req;
  logic [1:0]       fire_dir;
  logic [POS_W-1:0] fire_x;
  logic [POS_W-1:0] fire_y;
  logic             fire_ack;
  logic             fire_drop;

  modport master (
    output fire_req, fire_dir, fire_x, fire_y,
    input  fire_ack, fire_drop
  );

  modport slave (
    input  fire_req, fire_dir, fire_x, fire_y,
    output fire_ack, fire_drop
  );
endinterface

// File: rtl/bullet_pool.sv
// Multi-slot projectile engine: launch, per-tick movement, boundary retire, kill, VGA overlay.
// Optional BULLET_FIRE_COOLDOWN_EN adds a move_tick-based fire lockout after each accepted fire.
module bullet_pool #(
  parameter int unsigned NUM_BUL  = 4,
  parameter int unsigned POS_W    = 5,
  parameter int unsigned GRID_W   = 16,
  parameter int unsigned GRID_H   = 20,
  parameter int unsigned CELL     = 20,
  parameter int unsigned X_ORG    = 160,
  parameter int unsigned Y_ORG    = 40,
  parameter int unsigned HALF     = 3,
  parameter logic [11:0] COLOR    = 12'hFFF,
  parameter int unsigned COOLDOWN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     move_tick,
  bullet_pool_if.slave             fire,
  input  logic [NUM_BUL-1:0]       kill_vec,
  output logic [NUM_BUL-1:0]       bul_active,
  output logic [NUM_BUL*POS_W-1:0] bul_x,
  output logic [NUM_BUL*POS_W-1:0] bul_y,
  output logic [NUM_BUL-1:0]       retire_vec,
  input  logic [10:0]              VGA_xpos,
  input  logic [10:0]              VGA_ypos,
  output logic [11:0]              VGA_data,
  output logic                     VGA_en
);

  if (NUM_BUL < 1 || NUM_BUL > 8 || COOLDOWN > 255) begin : g_param_err
    $error("bullet_pool: NUM_BUL must be 1..8 and COOLDOWN at most 255");
  end

  typedef enum logic {S_IDLE = 1'b0, S_FLY = 1'b1} slot_state_e;

  slot_state_e      state_q [NUM_BUL];
  slot_state_e      state_d [NUM_BUL];
  logic [POS_W-1:0] x_q     [NUM_BUL];
  logic [POS_W-1:0] x_d     [NUM_BUL];
  logic [POS_W-1:0] y_q     [NUM_BUL];
  logic [POS_W-1:0] y_d     [NUM_BUL];
  logic [1:0]       dir_q   [NUM_BUL];
  logic [1:0]       dir_d   [NUM_BUL];
  logic [NUM_BUL-1:0] retire_d;
  logic ack_d, drop_d;
  logic in_field, cd_ok, accept, loaded;
  logic [11:0] cx [NUM_BUL];
  logic [11:0] cy [NUM_BUL];
  logic [11:0] xp, yp;
  logic hit;

`ifdef BULLET_FIRE_COOLDOWN_EN
  logic [7:0] cd_q;

  assign cd_ok = (cd_q == '0);

  // A fire accepted on a tick edge reloads the full lockout rather than decrementing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd_q <= '0;
    end else if (ack_d) begin
      cd_q <= 8'(COOLDOWN);
    end else if (move_tick && cd_q != '0) begin
      cd_q <= cd_q - 8'd1;
    end
  end
`else
  assign cd_ok = 1'b1;
`endif

  assign in_field = (32'(fire.fire_x) < GRID_W) && (32'(fire.fire_y) < GRID_H);
  assign accept   = fire.fire_req && in_field && cd_ok;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    retire_d = '0;
    loaded   = 1'b0;
    ack_d    = 1'b0;
    drop_d   = 1'b0;

    for (int unsigned i = 0; i < NUM_BUL; i++) begin
      if (state_q[i] == S_FLY) begin
        if (kill_vec[i]) begin
          state_d[i] = S_IDLE;
        end else if (move_tick) begin
          case (dir_q[i])
            2'b00: if (y_q[i] == '0) begin
                     state_d[i] = S_IDLE; retire_d[i] = 1'b1;
                   end else y_d[i] = y_q[i] - POS_W'(1);
            2'b01: if (32'(y_q[i]) == GRID_H - 1) begin
                     state_d[i] = S_IDLE; retire_d[i] = 1'b1;
                   end else y_d[i] = y_q[i] + POS_W'(1);
            2'b10: if (x_q[i] == '0) begin
                     state_d[i] = S_IDLE; retire_d[i] = 1'b1;
                   end else x_d[i] = x_q[i] - POS_W'(1);
            default: if (32'(x_q[i]) == GRID_W - 1) begin
                     state_d[i] = S_IDLE; retire_d[i] = 1'b1;
                   end else x_d[i] = x_q[i] + POS_W'(1);
          endcase
        end
      end
    end

    // Free slot comes from registered state, so slots retiring or killed now stay unavailable.
    for (int unsigned i = 0; i < NUM_BUL; i++) begin
      if (accept && !loaded && state_q[i] == S_IDLE) begin
        loaded     = 1'b1;
        state_d[i] = S_FLY;
        x_d[i]     = fire.fire_x;
        y_d[i]     = fire.fire_y;
        dir_d[i]   = fire.fire_dir;
      end
    end

    ack_d  = loaded;
    drop_d = fire.fire_req && !loaded;
  end

  always_comb begin
    xp  = {1'b0, VGA_xpos};
    yp  = {1'b0, VGA_ypos};
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_BUL; i++) begin
      cx[i] = 12'(x_q[i]) * 12'(CELL) + 12'(X_ORG);
      cy[i] = 12'(y_q[i]) * 12'(CELL) + 12'(Y_ORG);
      if (state_q[i] == S_FLY &&
          xp + 12'(HALF) >= cx[i] && xp <= cx[i] + 12'(HALF) &&
          yp + 12'(HALF) >= cy[i] && yp <= cy[i] + 12'(HALF)) begin
        hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_BUL; i++) begin
        state_q[i] <= S_IDLE;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        dir_q[i]   <= '0;
      end
      retire_vec     <= '0;
      fire.fire_ack  <= 1'b0;
      fire.fire_drop <= 1'b0;
      VGA_en         <= 1'b0;
      VGA_data       <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_BUL; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        dir_q[i]   <= dir_d[i];
      end
      retire_vec     <= retire_d;
      fire.fire_ack  <= ack_d;
      fire.fire_drop <= drop_d;
      VGA_en         <= hit;
      VGA_data       <= hit ? COLOR : '0;
    end
  end

  always_comb begin
    bul_active = '0;
    bul_x      = '0;
    bul_y      = '0;
    for (int unsigned i = 0; i < NUM_BUL; i++) begin
      bul_active[i]            = (state_q[i] == S_FLY);
      bul_x[i*POS_W +: POS_W]  = x_q[i];
      bul_y[i*POS_W +: POS_W]  = y_q[i];
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Scoreboard bench for bullet_pool: stimulus updates a slot-list model and queues expectations,
// an independent monitor compares DUT outputs after every clock edge.
module tb_bullet_pool;
  localparam int NB = 4, PW = 5, GW = 16, GH = 20, CELL = 20;
  localparam int XO = 160, YO = 40, HALF = 3, CD = 2;

  logic clk = 1'b0;
  logic rst;
  logic move_tick;
  logic [NB-1:0] kill_vec;
  logic [NB-1:0] bul_active;
  logic [NB*PW-1:0] bul_x, bul_y;
  logic [NB-1:0] retire_vec;
  logic [10:0] VGA_xpos, VGA_ypos;
  logic [11:0] VGA_data;
  logic VGA_en;

  always #5 clk = ~clk;

  bullet_pool_if #(.POS_W(PW)) fif ();

  bullet_pool #(
    .NUM_BUL(NB), .POS_W(PW), .GRID_W(GW), .GRID_H(GH), .CELL(CELL),
    .X_ORG(XO), .Y_ORG(YO), .HALF(HALF), .COLOR(12'hFFF), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .fire(fif),
    .kill_vec(kill_vec), .bul_active(bul_active), .bul_x(bul_x), .bul_y(bul_y),
    .retire_vec(retire_vec), .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos),
    .VGA_data(VGA_data), .VGA_en(VGA_en)
  );

  typedef struct packed {
    logic [NB-1:0]    act;
    logic [NB*PW-1:0] bx;
    logic [NB*PW-1:0] by;
    logic [NB-1:0]    ret;
    logic             ven;
  } snap_t;

  snap_t sq[$];
  bit    fq[$];
  int checks = 0, errors = 0;

  bit ml[NB];
  int mx[NB], my[NB], md[NB];
  int mcd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      ml[i] = 0; mx[i] = 0; my[i] = 0; md[i] = 0;
    end
    mcd = 0;
  endtask

  task automatic step(input bit fr, input int fd, input int fx, input int fy,
                      input bit mt, input logic [NB-1:0] kv, input int vx, input int vy);
    bit hit, acc;
    int free, nx, ny;
    snap_t s;
    @(negedge clk);
    fif.fire_req = fr;
    fif.fire_dir = 2'(fd);
    fif.fire_x   = PW'(fx);
    fif.fire_y   = PW'(fy);
    move_tick    = mt;
    kill_vec     = kv;
    VGA_xpos     = 11'(vx);
    VGA_ypos     = 11'(vy);

    hit = 0;
    for (int i = 0; i < NB; i++)
      if (ml[i] && iabs(vx - (mx[i] * CELL + XO)) <= HALF && iabs(vy - (my[i] * CELL + YO)) <= HALF)
        hit = 1;
    free = -1;
    for (int i = 0; i < NB; i++)
      if (!ml[i] && free < 0) free = i;

    s.ret = '0;
    for (int i = 0; i < NB; i++) begin
      if (ml[i]) begin
        if (kv[i]) ml[i] = 0;
        else if (mt) begin
          nx = mx[i] + ((md[i] == 2) ? -1 : (md[i] == 3) ? 1 : 0);
          ny = my[i] + ((md[i] == 0) ? -1 : (md[i] == 1) ? 1 : 0);
          if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            ml[i] = 0; s.ret[i] = 1'b1;
          end else begin
            mx[i] = nx; my[i] = ny;
          end
        end
      end
    end

    acc = 0;
    if (fr) begin
`ifdef BULLET_FIRE_COOLDOWN_EN
      acc = (free >= 0) && fx < GW && fy < GH && mcd == 0;
`else
      acc = (free >= 0) && fx < GW && fy < GH;
`endif
      fq.push_back(acc);
      if (acc) begin
        ml[free] = 1; mx[free] = fx; my[free] = fy; md[free] = fd;
      end
    end
`ifdef BULLET_FIRE_COOLDOWN_EN
    if (acc) mcd = CD;
    else if (mt && mcd > 0) mcd--;
`endif

    for (int i = 0; i < NB; i++) begin
      s.act[i]          = ml[i];
      s.bx[i*PW +: PW]  = PW'(mx[i]);
      s.by[i*PW +: PW]  = PW'(my[i]);
    end
    s.ven = hit;
    sq.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic rand_steps(input int n);
    int j, vx, vy;
    logic [NB-1:0] kv;
    for (int k = 0; k < n; k++) begin
      j  = $urandom_range(0, NB - 1);
      vx = mx[j] * CELL + XO + int'($urandom_range(0, 10)) - 5;
      vy = my[j] * CELL + YO + int'($urandom_range(0, 10)) - 5;
      for (int b = 0; b < NB; b++) kv[b] = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 17),
           $urandom_range(0, 21), $urandom_range(0, 3) == 0, kv, vx, vy);
    end
  endtask

  // Monitor: compares after each rising edge, independently of the stimulus process.
  initial begin
    snap_t s;
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("bul_active", 64'(bul_active), 64'(s.act));
        chk("bul_x", 64'(bul_x), 64'(s.bx));
        chk("bul_y", 64'(bul_y), 64'(s.by));
        chk("retire_vec", 64'(retire_vec), 64'(s.ret));
        chk("VGA_en", 64'(VGA_en), 64'(s.ven));
        chk("VGA_data", 64'(VGA_data), s.ven ? 64'hFFF : 64'h0);
      end
      if (fif.fire_ack || fif.fire_drop) begin
        if (fq.size() == 0) begin
          checks++; errors++;
          $display("FAIL fire_resp actual ack=%b drop=%b required none", fif.fire_ack, fif.fire_drop);
        end else begin
          e = fq.pop_front();
          chk("fire_ack", 64'(fif.fire_ack), 64'(e));
          chk("fire_drop", 64'(fif.fire_drop), 64'(!e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    fif.fire_req = 0; fif.fire_dir = '0; fif.fire_x = '0; fif.fire_y = '0;
    move_tick = 0; kill_vec = '0; VGA_xpos = '0; VGA_ypos = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_active", 64'(bul_active), 64'h0);
    chk("rst_x", 64'(bul_x), 64'h0);
    chk("rst_y", 64'(bul_y), 64'h0);
    chk("rst_resp", 64'({fif.fire_ack, fif.fire_drop, retire_vec}), 64'h0);
    chk("rst_vga", 64'({VGA_en, VGA_data}), 64'h0);
    rst = 1'b0;

    // Launch, three moves, then sweep the drawn square edges.
    step(1, 3, 5, 5, 0, '0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, '0, 0, 0);
    for (int v = 316; v <= 324; v++) step(0, 0, 0, 0, 0, '0, v, 140);
    for (int v = 136; v <= 144; v++) step(0, 0, 0, 0, 0, '0, 320, v);
    step(0, 0, 0, 0, 0, '1, 0, 0);
    idle(3);

    // Right-edge retire.
    step(1, 3, 15, 3, 0, '0, 0, 0);
    step(0, 0, 0, 0, 1, '0, 0, 0);
    idle(3);

    // Fill the pool, overflow, kill slot 2, refill.
    repeat (5) step(1, 1, 2, 2, 0, '0, 0, 0);
    step(0, 0, 0, 0, 0, 4'b0100, 0, 0);
    step(1, 2, 9, 9, 0, '0, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, '0, 0, 0);

    // Fire together with a tick; kill together with a boundary tick.
    step(1, 0, 3, 10, 0, '0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, '0, 0, 0);
    step(1, 1, 7, 7, 1, '0, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, '0, 0, 0);
    step(1, 0, 2, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, 1, 4'b0001, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, '0, 0, 0);

    // Cooldown pattern: fire, fire, tick, fire, tick, fire.
    step(1, 1, 1, 1, 0, '0, 0, 0);
    step(1, 1, 2, 1, 0, '0, 0, 0);
    step(0, 0, 0, 0, 1, '0, 0, 0);
    step(1, 1, 3, 1, 0, '0, 0, 0);
    step(0, 0, 0, 0, 1, '0, 0, 0);
    step(1, 1, 4, 1, 0, '0, 0, 0);
    step(0, 0, 0, 0, 0, '1, 0, 0);

    rand_steps(600);
    idle(1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_active", 64'(bul_active), 64'h0);
    chk("midrst_x", 64'(bul_x), 64'h0);
    chk("midrst_y", 64'(bul_y), 64'h0);
    chk("midrst_vga", 64'({VGA_en, VGA_data}), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    rand_steps(300);
    idle(2);
    repeat (3) @(posedge clk);
    #2;
    chk("fire_q_drained", 64'(fq.size()), 64'h0);
    chk("snap_q_drained", 64'(sq.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
